alu_share_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two independent requesters (port 0, port 1).
- Each requester uses a valid/ready handshake.
- Round-robin arbitration chooses which request drives the ALU each cycle. The ALU result is registered into a single-entry response buffer, tagged with the winning port ID.
- Sits between issue logic and the ALU instance; the ALU itself is external.

---
 rtl/alu_share_arbiter.sv | 77 +++++++
 tb/tb_alu_share_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one external ALU between two requesters
// Winner's operands drive the ALU; the result lands in a single-entry tagged response buffer.
module alu_share_arbiter #(
  parameter int W    = 32,
  parameter int CMDW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic [CMDW-1:0] req0_cmd,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic [CMDW-1:0] req1_cmd,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [CMDW-1:0] alu_cmd,
  input  logic [W-1:0]    alu_c,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_id,
  output logic            rsp_err
);

  logic can_accept;
  logic last_grant;
  logic grant0;
  logic grant1;
  logic accept;
  logic legal;

  function automatic logic cmd_legal(input logic [CMDW-1:0] c);
    return (c == CMDW'(0)) || (c == CMDW'(2)) ||
           ((c >= CMDW'(4)) && (c <= CMDW'(10)));
  endfunction

  // Buffer can take a new result if empty or being drained this cycle.
  assign can_accept = !rsp_valid || rsp_ready;

  assign grant0 = can_accept && req0_valid && (!req1_valid || last_grant);
  assign grant1 = can_accept && req1_valid && (!req0_valid || !last_grant);
  assign accept = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Port 0 drives the ALU whenever port 1 is not the winner.
  assign alu_a   = grant1 ? req1_a   : req0_a;
  assign alu_b   = grant1 ? req1_b   : req0_b;
  assign alu_cmd = grant1 ? req1_cmd : req0_cmd;

  assign legal = cmd_legal(alu_cmd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_data   <= legal ? alu_c : '0;
      rsp_id     <= grant1;
      rsp_err    <= !legal;
      last_grant <= grant1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;

  localparam int W    = 32;
  localparam int CMDW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req0_ready;
  logic [W-1:0]    req0_a, req0_b;
  logic [CMDW-1:0] req0_cmd;
  logic            req1_valid, req1_ready;
  logic [W-1:0]    req1_a, req1_b;
  logic [CMDW-1:0] req1_cmd;
  logic [W-1:0]    alu_a, alu_b, alu_c;
  logic [CMDW-1:0] alu_cmd;
  logic            rsp_valid, rsp_ready;
  logic [W-1:0]    rsp_data;
  logic            rsp_id, rsp_err;

  typedef struct packed {
    logic [W-1:0] d;
    logic         id;
    logic         err;
  } rsp_t;

  rsp_t q[$];
  rsp_t mon_e;
  int   vectors = 0;
  int   errors  = 0;

  alu_share_arbiter #(.W(W), .CMDW(CMDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // External ALU: 0 add, 2 sub, 4 and, 5 or, 6 xor, 7 sll, 8 srl, 9 sra, 10 slt
  always_comb begin
    alu_c = 32'hDEAD_BEEF;
    case (alu_cmd)
      4'd0:  alu_c = alu_a + alu_b;
      4'd2:  alu_c = alu_a - alu_b;
      4'd4:  alu_c = alu_a & alu_b;
      4'd5:  alu_c = alu_a | alu_b;
      4'd6:  alu_c = alu_a ^ alu_b;
      4'd7:  alu_c = alu_a << alu_b[4:0];
      4'd8:  alu_c = alu_a >> alu_b[4:0];
      4'd9:  alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd10: alu_c = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_c = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic id, input logic err);
    rsp_t e;
    e.d = d; e.id = id; e.err = err;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: every consumed response is matched against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL rsp_unexpected: got data %h id %0d err %0d, expected no response",
                 rsp_data, rsp_id, rsp_err);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_data", rsp_data, mon_e.d);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, mon_e.id});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cmd = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cmd = 0;
    rsp_ready = 1'b1;

    sample();
    chk("reset_valid", {31'd0, rsp_valid}, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_id", {31'd0, rsp_id}, 0);
    chk("reset_err", {31'd0, rsp_err}, 0);

    // 1: lone port 0 SUB 5-3
    step();
    rst_n = 1'b1;
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_cmd = 2;
    sample();
    chk("t1_ready0", {31'd0, req0_ready}, 1);
    chk("t1_alu_a", alu_a, 5);
    push(32'd2, 0, 0);
    step();
    req0_valid = 0;
    sample();
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 1);

    // 2: contested stream alternates 0,1,0,1
    do_reset();
    req0_valid = 1; req0_a = 7;     req0_b = 1;     req0_cmd = 0;
    req1_valid = 1; req1_a = 'hF0;  req1_b = 'h3C;  req1_cmd = 4;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t2_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 1 : 0);
      chk("t2_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) push(32'd8, 0, 0);
      else            push(32'h30, 1, 0);
      if (i < 3) step();
    end

    // 3: back-pressure with both valid (last grant was port 1, so port 0 first)
    step();
    sample();
    chk("t3_ready0", {31'd0, req0_ready}, 1);
    push(32'd8, 0, 0);
    step();
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t3_hold_ready0", {31'd0, req0_ready}, 0);
      chk("t3_hold_ready1", {31'd0, req1_ready}, 0);
      chk("t3_hold_data", rsp_data, 32'd8);
      chk("t3_hold_valid", {31'd0, rsp_valid}, 1);
      if (i < 2) step();
    end
    step();
    rsp_ready = 1;
    sample();
    chk("t3_refill_ready1", {31'd0, req1_ready}, 1);
    chk("t3_refill_ready0", {31'd0, req0_ready}, 0);
    push(32'h30, 1, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    sample();
    chk("t3_no_bubble", {31'd0, rsp_valid}, 1);

    // 4: illegal then legal SRA on port 1
    step();
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_cmd = 3;
    sample();
    chk("t4_ready1_a", {31'd0, req1_ready}, 1);
    push(32'd0, 1, 1);
    step();
    req1_a = 32'h8000_0000; req1_b = 4; req1_cmd = 9;
    sample();
    chk("t4_ready1_b", {31'd0, req1_ready}, 1);
    push(32'hF800_0000, 1, 0);
    step();
    req1_valid = 0;
    sample();

    // 5: asynchronous reset while FULL
    step();
    rsp_ready = 0;
    req0_valid = 1; req0_a = 32'h1000; req0_b = 32'h234; req0_cmd = 0;
    step();
    req0_valid = 0;
    sample();
    chk("t5_full_valid", {31'd0, rsp_valid}, 1);
    chk("t5_full_data", rsp_data, 32'h1234);
    #2;
    rst_n = 0;
    #1;
    chk("t5_async_valid", {31'd0, rsp_valid}, 0);
    chk("t5_async_data", rsp_data, 0);
    step();
    rst_n = 1;
    rsp_ready = 1;
    req0_valid = 1; req0_a = 2; req0_b = 3; req0_cmd = 0;
    req1_valid = 1; req1_a = 9; req1_b = 9; req1_cmd = 0;
    sample();
    chk("t5_post_ready0", {31'd0, req0_ready}, 1);
    chk("t5_post_ready1", {31'd0, req1_ready}, 0);
    push(32'd5, 0, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    sample();

    // 6: eight back-to-back ADDs on port 0
    for (int i = 0; i < 8; i++) begin
      step();
      req0_valid = 1; req0_a = i; req0_b = i; req0_cmd = 0;
      sample();
      chk("t6_ready0", {31'd0, req0_ready}, 1);
      if (i > 0) chk("t6_stream_valid", {31'd0, rsp_valid}, 1);
      push(2 * i, 0, 0);
    end
    step();
    req0_valid = 0;
    sample();
    chk("t6_last_valid", {31'd0, rsp_valid}, 1);
    step();
    sample();
    chk("t6_drained", {31'd0, rsp_valid}, 0);
    chk("t6_data_held", rsp_data, 32'd14);

    repeat (2) step();
    chk("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
